// File: rtl/alu_mdu_sequencer.sv
// ALU control decoder plus executor with a multicycle unsigned multiply/divide unit.
// Single-cycle ops complete one cycle after accept; MULT/DIV iterate WIDTH cycles into HI/LO.
module alu_mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       ALUOP,
  input  logic [5:0]       Function,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [3:0]       ALUS,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH:0]   hi_work_reg;
  logic [WIDTH-1:0] lo_work_reg;
  logic [WIDTH-1:0] opb_reg;

  logic [3:0]       dec_alus;
  logic             dec_illegal;
  logic [WIDTH-1:0] alu_res;
  logic             accept, is_mult, is_div, div_zero, last_iter;

  logic [WIDTH-1:0] mul_add;
  logic [WIDTH:0]   mul_sum, mul_hi_next, div_shift, div_diff, div_hi_next;
  logic [WIDTH-1:0] mul_lo_next, div_lo_next;
  logic             div_ok;

  always_comb begin
    dec_alus    = 4'b1110;
    dec_illegal = 1'b1;
    case (ALUOP)
      2'b00: begin dec_alus = 4'b0010; dec_illegal = 1'b0; end
      2'b01: begin dec_alus = 4'b0110; dec_illegal = 1'b0; end
      2'b10: begin
        dec_illegal = 1'b0;
        case (Function)
          6'b100000: dec_alus = 4'b0010;
          6'b100010: dec_alus = 4'b0110;
          6'b100101: dec_alus = 4'b0001;
          6'b100100: dec_alus = 4'b0000;
          6'b101010: dec_alus = 4'b0111;
          6'b011000: dec_alus = 4'b0101;
          6'b011010: dec_alus = 4'b1000;
          6'b000000: dec_alus = 4'b1111;
          default: begin dec_alus = 4'b1110; dec_illegal = 1'b1; end
        endcase
      end
      default: begin dec_alus = 4'b1110; dec_illegal = 1'b1; end
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (dec_alus)
      4'b0010: alu_res = A + B;
      4'b0110: alu_res = A - B;
      4'b0001: alu_res = A | B;
      4'b0000: alu_res = A & B;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: alu_res = '0;
    endcase
  end

  assign accept    = start && (state_reg == IDLE);
  assign is_mult   = (dec_alus == 4'b0101);
  assign is_div    = (dec_alus == 4'b1000);
  assign div_zero  = is_div && (B == '0);
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));
  assign busy      = (state_reg != IDLE);

  // Shift-add multiply: hi_work accumulates, lo_work holds the multiplier and collects product LSBs.
  assign mul_add     = lo_work_reg[0] ? opb_reg : '0;
  assign mul_sum     = hi_work_reg + {1'b0, mul_add};
  assign mul_hi_next = {1'b0, mul_sum[WIDTH:1]};
  assign mul_lo_next = {mul_sum[0], lo_work_reg[WIDTH-1:1]};

  // Restoring divide: hi_work is the partial remainder, lo_work shifts dividend out and quotient in.
  assign div_shift   = {hi_work_reg[WIDTH-1:0], lo_work_reg[WIDTH-1]};
  assign div_diff    = div_shift - {1'b0, opb_reg};
  assign div_ok      = ~div_diff[WIDTH];
  assign div_hi_next = div_ok ? div_diff : div_shift;
  assign div_lo_next = {lo_work_reg[WIDTH-2:0], div_ok};

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && is_mult)                 state_next = MUL;
        else if (accept && is_div && !div_zero) state_next = DIV;
      end
      MUL, DIV: if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ALUS        <= '0;
      result      <= '0;
      HI          <= '0;
      LO          <= '0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      cnt_reg     <= '0;
      hi_work_reg <= '0;
      lo_work_reg <= '0;
      opb_reg     <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: if (accept) begin
          ALUS        <= dec_alus;
          illegal     <= 1'b0;
          cnt_reg     <= '0;
          hi_work_reg <= '0;
          lo_work_reg <= A;
          opb_reg     <= B;
          if (div_zero) begin
            HI      <= A;
            LO      <= '1;
            result  <= '1;
            illegal <= 1'b1;
            done    <= 1'b1;
          end else if (!is_mult && !is_div) begin
            result  <= alu_res;
            illegal <= dec_illegal;
            done    <= 1'b1;
          end
        end
        MUL: begin
          cnt_reg     <= cnt_reg + CW'(1);
          hi_work_reg <= mul_hi_next;
          lo_work_reg <= mul_lo_next;
          if (last_iter) begin
            HI     <= mul_hi_next[WIDTH-1:0];
            LO     <= mul_lo_next;
            result <= mul_lo_next;
            done   <= 1'b1;
          end
        end
        DIV: begin
          cnt_reg     <= cnt_reg + CW'(1);
          hi_work_reg <= div_hi_next;
          lo_work_reg <= div_lo_next;
          if (last_iter) begin
            HI     <= div_hi_next[WIDTH-1:0];
            LO     <= div_lo_next;
            result <= div_lo_next;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_sequencer.sv
// Scoreboard bench for alu_mdu_sequencer: stimulus pushes hand-computed expectations,
// a negedge monitor pops one per done pulse and checks values, latency and busy length.
module tb_alu_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  ALUOP;
  logic [5:0]  Function;
  logic [31:0] A, B;
  logic [3:0]  ALUS;
  logic [31:0] result, HI, LO;
  logic        busy, done, illegal;

  alu_mdu_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUOP(ALUOP), .Function(Function),
    .A(A), .B(B), .ALUS(ALUS), .result(result), .HI(HI), .LO(LO),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res, hi, lo;
    logic [3:0]  alus;
    logic        ill;
    int          lat, bsy, issue;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   busy_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst) busy_cnt = 0;
    else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          $display("txn %s: result=%h HI=%h LO=%h ALUS=%b illegal=%b lat=%0d busy=%0d",
                   e.name, result, HI, LO, ALUS, illegal, cyc - e.issue, busy_cnt);
          chk({e.name, ".result"},  result, e.res);
          chk({e.name, ".HI"},      HI, e.hi);
          chk({e.name, ".LO"},      LO, e.lo);
          chk({e.name, ".ALUS"},    ALUS, e.alus);
          chk({e.name, ".illegal"}, illegal, e.ill);
          chk({e.name, ".latency"}, cyc - e.issue, e.lat);
          chk({e.name, ".busy"},    busy_cnt, e.bsy);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input string nm, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [31:0] h, input logic [31:0] l,
                       input logic [3:0] al, input logic il, input int lat, input int bz);
    exp_t e;
    @(negedge clk);
    start = 1'b1; ALUOP = op; Function = fn; A = a; B = b;
    e.name = nm; e.res = r; e.hi = h; e.lo = l; e.alus = al; e.ill = il;
    e.lat = lat; e.bsy = bz; e.issue = cyc;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("wait_timeout", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ALUOP = 2'b00; Function = 6'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("rst.ALUS", ALUS, 0);  chk("rst.result", result, 0);
    chk("rst.HI", HI, 0);      chk("rst.LO", LO, 0);
    chk("rst.busy", busy, 0);  chk("rst.done", done, 0);
    chk("rst.illegal", illegal, 0);
    rst = 1'b0;

    issue("add_5_7", 2'b10, 6'b100000, 32'd5, 32'd7, 32'd12, 0, 0, 4'b0010, 0, 1, 0);
    idle(); wait_empty();
    issue("aluop01_sub", 2'b01, 6'b000000, 32'd20, 32'd7, 32'd13, 0, 0, 4'b0110, 0, 1, 0);
    idle(); wait_empty();
    issue("aluop00_add", 2'b00, 6'b111111, 32'd3, 32'd4, 32'd7, 0, 0, 4'b0010, 0, 1, 0);
    idle(); wait_empty();
    // Back-to-back pairs: second start is held through the first op's done cycle
    issue("or", 2'b10, 6'b100101, 32'hF0, 32'h0F, 32'hFF, 0, 0, 4'b0001, 0, 1, 0);
    issue("and", 2'b10, 6'b100100, 32'hFF, 32'h3C, 32'h3C, 0, 0, 4'b0000, 0, 1, 0);
    idle(); wait_empty();
    issue("slt_m1_1", 2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 0, 4'b0111, 0, 1, 0);
    issue("slt_1_m1", 2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF, 32'd0, 0, 0, 4'b0111, 0, 1, 0);
    idle(); wait_empty();
    issue("sub_wrap", 2'b10, 6'b100010, 32'd0, 32'd1, 32'hFFFFFFFF, 0, 0, 4'b0110, 0, 1, 0);
    issue("add_wrap", 2'b10, 6'b100000, 32'hFFFFFFFF, 32'd2, 32'd1, 0, 0, 4'b0010, 0, 1, 0);
    idle(); wait_empty();
    issue("nop", 2'b10, 6'b000000, 32'd9, 32'd9, 32'd0, 0, 0, 4'b1111, 0, 1, 0);
    idle(); wait_empty();
    issue("fn_illegal", 2'b10, 6'b111111, 32'd5, 32'd7, 32'd0, 0, 0, 4'b1110, 1, 1, 0);
    issue("aluop11", 2'b11, 6'b100000, 32'd5, 32'd7, 32'd0, 0, 0, 4'b1110, 1, 1, 0);
    issue("add_clr_ill", 2'b10, 6'b100000, 32'd1, 32'd1, 32'd2, 0, 0, 4'b0010, 0, 1, 0);
    idle(); wait_empty();

    // MULT with an ignored SUB start mid-flight and operands changing
    issue("mult_ff_2", 2'b10, 6'b011000, 32'hFFFFFFFF, 32'd2,
          32'hFFFFFFFE, 32'd1, 32'hFFFFFFFE, 4'b0101, 0, 33, 32);
    idle();
    repeat (3) @(negedge clk);
    start = 1'b1; ALUOP = 2'b01; A = 32'd50; B = 32'd8;
    @(negedge clk);
    start = 1'b0;
    wait_empty();

    issue("div_100_7", 2'b10, 6'b011010, 32'd100, 32'd7,
          32'd14, 32'd2, 32'd14, 4'b1000, 0, 33, 32);
    idle(); wait_empty();
    issue("div_9_0", 2'b10, 6'b011010, 32'd9, 32'd0,
          32'hFFFFFFFF, 32'd9, 32'hFFFFFFFF, 4'b1000, 1, 1, 0);
    idle(); wait_empty();
    issue("add_hold_hilo", 2'b10, 6'b100000, 32'd1, 32'd1,
          32'd2, 32'd9, 32'hFFFFFFFF, 4'b0010, 0, 1, 0);
    idle(); wait_empty();
    issue("mult_big", 2'b10, 6'b011000, 32'h12345678, 32'h10,
          32'h23456780, 32'd1, 32'h23456780, 4'b0101, 0, 33, 32);
    idle(); wait_empty();
    issue("div_max_10", 2'b10, 6'b011010, 32'hFFFFFFFF, 32'd10,
          32'h19999999, 32'd5, 32'h19999999, 4'b1000, 0, 33, 32);
    idle(); wait_empty();

    // Reset mid-DIV: the partial op is discarded, no expectation queued
    @(negedge clk);
    start = 1'b1; ALUOP = 2'b10; Function = 6'b011010; A = 32'd100; B = 32'd7;
    idle();
    repeat (8) @(negedge clk);
    chk("middiv.busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2.ALUS", ALUS, 0);  chk("rst2.result", result, 0);
    chk("rst2.HI", HI, 0);      chk("rst2.LO", LO, 0);
    chk("rst2.busy", busy, 0);  chk("rst2.done", done, 0);
    chk("rst2.illegal", illegal, 0);
    rst = 1'b0;
    issue("add_after_rst", 2'b10, 6'b100000, 32'd2, 32'd3, 32'd5, 0, 0, 4'b0010, 0, 1, 0);
    idle(); wait_empty();
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
